// File: rtl/stream_serializer_pkg.sv
// -----------------------------------------------------------------------------
// stream_serializer_pkg
//   Shared link definitions for the inter-FPGA message path. The serializer,
//   the per-link FIFO instances and the future deserializer all take their beat
//   width and maximum beats per message from here, so they always agree.
//   Also holds the serializer FSM state type.
// -----------------------------------------------------------------------------
package stream_serializer_pkg;

    // Width of one link beat in bits.
    localparam int LINK_BEAT_WIDTH = 8;
    // Maximum beats per message. Must be >= 2; need not be a power of 2.
    localparam int LINK_NUM_BEATS  = 4;

    // IDLE: no message held.  SEND: a message is held and beats are pending.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage : stream_serializer_pkg

// File: rtl/stream_serializer_if.sv
// -----------------------------------------------------------------------------
// stream_serializer_if
//   Groups both valid/ready links of the serializer plus its busy status.
//   Handshake rule on both links: a transfer happens on a rising clk edge where
//   valid & ready are both high. A source that raises valid keeps valid and
//   its payload stable until that transfer. A source must not make valid
//   depend on ready.
//
//   Signals
//     in_valid  / in_ready  / in_data / in_len : wide message into the serializer
//     out_valid / out_ready / out_data / out_last : narrow beats out of it
//     busy                                      : a message is in flight
//
//   Modports
//     slave  : the serializer's view (consumes messages, produces beats)
//     master : the environment's view (produces messages, consumes beats)
// -----------------------------------------------------------------------------
interface stream_serializer_if
    import stream_serializer_pkg::*;
#(
    parameter int BEAT_WIDTH = LINK_BEAT_WIDTH,
    parameter int NUM_BEATS  = LINK_NUM_BEATS
);
    localparam int LEN_W = $clog2(NUM_BEATS + 1);

    logic                            in_valid;
    logic                            in_ready;
    logic [BEAT_WIDTH*NUM_BEATS-1:0] in_data;
    logic [LEN_W-1:0]                in_len;

    logic                            out_valid;
    logic                            out_ready;
    logic [BEAT_WIDTH-1:0]           out_data;
    logic                            out_last;

    logic                            busy;

    modport slave (
        input  in_valid, in_data, in_len, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );

    modport master (
        output in_valid, in_data, in_len, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

endinterface : stream_serializer_if

// File: rtl/stream_serializer.sv
// -----------------------------------------------------------------------------
// stream_serializer
//   Accepts one wide message (NUM_BEATS x BEAT_WIDTH) with a beat count and
//   emits it as 1..NUM_BEATS narrow beats, LSB beat first, with out_last on the
//   final beat. Sustains one beat per cycle with no bubble between messages.
//
//   Ports
//     clk   : single clock, rising edge
//     reset : asynchronous, active-high
//     bus   : stream_serializer_if.slave (message in, beats out, busy)
//
//   in_len of 0 or above NUM_BEATS is treated as NUM_BEATS.
//   in_ready has a combinational path from out_ready: the last beat's
//   handshake frees the hold register in the same cycle, which is what lets
//   the next message load without a bubble.
//   busy is the FSM state (1 = SEND).
// -----------------------------------------------------------------------------
module stream_serializer
    import stream_serializer_pkg::*;
#(
    parameter int BEAT_WIDTH = LINK_BEAT_WIDTH,
    parameter int NUM_BEATS  = LINK_NUM_BEATS
) (
    input  logic               clk,
    input  logic               reset,
    stream_serializer_if.slave bus
);

    localparam int LEN_W = $clog2(NUM_BEATS + 1);
    localparam int MSG_W = BEAT_WIDTH * NUM_BEATS;

    state_t             state, state_next;
    logic [MSG_W-1:0]   hold, hold_next;
    logic [LEN_W-1:0]   len_q, len_next;
    logic [LEN_W-1:0]   idx, idx_next;

    logic [LEN_W-1:0]   len_clamped;
    logic [LEN_W-1:0]   last_idx;
    logic               is_last;
    logic               out_fire;
    logic               in_ready_c;
    logic               in_fire;

    // Length clamp: 0 and out-of-range counts both mean "full message".
    always_comb begin
        len_clamped = bus.in_len;
        if (bus.in_len == '0 || bus.in_len > LEN_W'(NUM_BEATS)) begin
            len_clamped = LEN_W'(NUM_BEATS);
        end
    end

    // len_q is never 0 while in SEND, so last_idx never underflows there.
    assign last_idx   = len_q - LEN_W'(1);
    assign is_last    = (state == SEND) && (idx == last_idx);
    assign out_fire   = (state == SEND) && bus.out_ready;
    assign in_ready_c = (state == IDLE) || (is_last && bus.out_ready);
    assign in_fire    = bus.in_valid && in_ready_c;

    // State register and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            hold  <= '0;
            len_q <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            hold  <= hold_next;
            len_q <= len_next;
            idx   <= idx_next;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_next = state;
        hold_next  = hold;
        len_next   = len_q;
        idx_next   = idx;

        if (state == IDLE) begin
            if (in_fire) begin
                state_next = SEND;
                hold_next  = bus.in_data;
                len_next   = len_clamped;
                idx_next   = '0;
            end
        end else begin
            if (out_fire) begin
                if (!is_last) begin
                    // Next beat moves into the low slice; idx stops at len-1.
                    hold_next = hold >> BEAT_WIDTH;
                    idx_next  = idx + LEN_W'(1);
                end else if (in_fire) begin
                    // Last beat leaves while the next message loads: no bubble.
                    hold_next = bus.in_data;
                    len_next  = len_clamped;
                    idx_next  = '0;
                end else begin
                    state_next = IDLE;
                end
            end
        end
    end

    // Outputs are gated by state so IDLE (including right after reset or a
    // completed message) always shows out_data=0 and out_last=0.
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state == SEND);
    assign bus.out_data  = (state == SEND) ? hold[BEAT_WIDTH-1:0] : '0;
    assign bus.out_last  = is_last;
    assign bus.busy      = (state == SEND);

endmodule : stream_serializer

// File: tb/tb_stream_serializer.sv
// -----------------------------------------------------------------------------
// tb_stream_serializer
//   Bench for stream_serializer with BEAT_WIDTH=8, NUM_BEATS=4.
//   Inputs are driven 2 ns after each rising edge; outputs are sampled on the
//   falling edge, so every vector row describes one clock cycle.
// -----------------------------------------------------------------------------
module tb_stream_serializer;

    localparam int BW    = 8;
    localparam int NB    = 4;
    localparam int LEN_W = $clog2(NB + 1);

    // ---------------------------------------------------------------- clock/reset
    logic clk;
    logic reset;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    stream_serializer_if #(.BEAT_WIDTH(BW), .NUM_BEATS(NB)) bus ();

    stream_serializer #(.BEAT_WIDTH(BW), .NUM_BEATS(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------------------------------------------------------- scoreboard
    int n_checks;
    int n_errors;
    logic [BW:0] exp_q[$];   // {last, data}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- vector table
    typedef struct {
        logic             iv;
        logic [31:0]      d;
        logic [LEN_W-1:0] len;
        logic             ordy;
        logic             ov;
        logic [BW-1:0]    od;
        logic             ol;
        logic             ir;
        logic             bsy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [31:0] d, input logic [LEN_W-1:0] len,
                       input logic ordy, input logic ov, input logic [BW-1:0] od,
                       input logic ol, input logic ir, input logic bsy);
        vec_t v;
        v.iv = iv; v.d = d; v.len = len; v.ordy = ordy;
        v.ov = ov; v.od = od; v.ol = ol; v.ir = ir; v.bsy = bsy;
        vecs.push_back(v);
    endtask

    // ---------------------------------------------------------------- driver
    task automatic drive(input logic iv, input logic [31:0] d, input logic [LEN_W-1:0] len,
                         input logic ordy);
        @(posedge clk);
        #2;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_len    = len;
        bus.out_ready = ordy;
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
        check({tag, "_out_data"},  32'(bus.out_data),  32'h0);
        check({tag, "_out_last"},  32'(bus.out_last),  32'h0);
        check({tag, "_busy"},      32'(bus.busy),      32'h0);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'h1);
    endtask

    // ---------------------------------------------------------------- random run state
    localparam int NMSG   = 300;
    localparam int BUDGET = 20000;

    initial begin
        logic [31:0]      md;
        logic [LEN_W-1:0] ml;
        logic             offering;
        int               sent;
        int               cyc;
        int               lc;
        logic [BW:0]      e;

        n_checks = 0;
        n_errors = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_len    = '0;
        bus.out_ready = 1'b0;

        // ------------------------------------------------ reset state
        repeat (2) @(negedge clk);
        check_idle("in_reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle("after_reset");

        // ------------------------------------------------ vector table
        //  iv  data          len  ordy | ov  od     ol  ir  busy
        // full message, out_ready always 1
        add(1, 32'hDDCCBBAA, 3'd4, 1,    0, 8'h00, 0, 1, 0);
        add(0, 32'h0,        3'd0, 1,    1, 8'hAA, 0, 0, 1);
        add(0, 32'h0,        3'd0, 1,    1, 8'hBB, 0, 0, 1);
        add(0, 32'h0,        3'd0, 1,    1, 8'hCC, 0, 0, 1);
        add(0, 32'h0,        3'd0, 1,    1, 8'hDD, 1, 1, 1);
        // back-to-back: len 4 then len 1 with no gap
        add(1, 32'h44332211, 3'd4, 1,    0, 8'h00, 0, 1, 0);
        add(0, 32'h0,        3'd0, 1,    1, 8'h11, 0, 0, 1);
        add(0, 32'h0,        3'd0, 1,    1, 8'h22, 0, 0, 1);
        add(0, 32'h0,        3'd0, 1,    1, 8'h33, 0, 0, 1);
        add(1, 32'h000000EE, 3'd1, 1,    1, 8'h44, 1, 1, 1);
        add(0, 32'h0,        3'd0, 1,    1, 8'hEE, 1, 1, 1);
        // backpressure len 3, out_ready 1,0,0,1,0,1; in_data scrambled after accept
        add(1, 32'h77665544, 3'd3, 1,    0, 8'h00, 0, 1, 0);
        add(0, 32'hFFFFFFFF, 3'd0, 1,    1, 8'h44, 0, 0, 1);
        add(0, 32'hFFFFFFFF, 3'd0, 0,    1, 8'h55, 0, 0, 1);
        add(0, 32'hFFFFFFFF, 3'd0, 0,    1, 8'h55, 0, 0, 1);
        add(0, 32'hFFFFFFFF, 3'd0, 1,    1, 8'h55, 0, 0, 1);
        add(0, 32'hFFFFFFFF, 3'd0, 0,    1, 8'h66, 1, 0, 1);
        add(0, 32'hFFFFFFFF, 3'd0, 1,    1, 8'h66, 1, 1, 1);
        add(0, 32'h0,        3'd0, 1,    0, 8'h00, 0, 1, 0);
        // clamp: len 0 -> 4, len 7 -> 4, then len 2
        add(1, 32'h04030201, 3'd0, 1,    0, 8'h00, 0, 1, 0);
        add(0, 32'h0,        3'd0, 1,    1, 8'h01, 0, 0, 1);
        add(0, 32'h0,        3'd0, 1,    1, 8'h02, 0, 0, 1);
        add(0, 32'h0,        3'd0, 1,    1, 8'h03, 0, 0, 1);
        add(1, 32'h0D0C0B0A, 3'd7, 1,    1, 8'h04, 1, 1, 1);
        add(0, 32'h0,        3'd0, 1,    1, 8'h0A, 0, 0, 1);
        add(0, 32'h0,        3'd0, 1,    1, 8'h0B, 0, 0, 1);
        add(0, 32'h0,        3'd0, 1,    1, 8'h0C, 0, 0, 1);
        add(1, 32'hFFFF5A3C, 3'd2, 1,    1, 8'h0D, 1, 1, 1);
        add(0, 32'h0,        3'd0, 1,    1, 8'h3C, 0, 0, 1);
        add(0, 32'h0,        3'd0, 1,    1, 8'h5A, 1, 1, 1);
        add(0, 32'h0,        3'd0, 1,    0, 8'h00, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].len, vecs[i].ordy);
            check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ov));
            check($sformatf("vec%0d_out_data", i),  32'(bus.out_data),  32'(vecs[i].od));
            check($sformatf("vec%0d_out_last", i),  32'(bus.out_last),  32'(vecs[i].ol));
            check($sformatf("vec%0d_in_ready", i),  32'(bus.in_ready),  32'(vecs[i].ir));
            check($sformatf("vec%0d_busy", i),      32'(bus.busy),      32'(vecs[i].bsy));
        end

        // ------------------------------------------------ reset mid-message
        drive(1, 32'h99887766, 3'd4, 1);
        drive(0, 32'h0, 3'd0, 1);              // beat 66
        check("mid_beat0", 32'(bus.out_data), 32'h66);
        drive(0, 32'h0, 3'd0, 1);              // beat 77
        check("mid_beat1", 32'(bus.out_data), 32'h77);
        @(posedge clk);
        #3;                                    // off-edge assertion
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("mid_rst_busy",      32'(bus.busy),      32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rel_in_ready",  32'(bus.in_ready),  32'h1);
        check("mid_rel_out_valid", 32'(bus.out_valid), 32'h0);
        drive(1, 32'h87654321, 3'd4, 1);
        drive(0, 32'h0, 3'd0, 1);
        check("mid_next_beat0", 32'(bus.out_data), 32'h21);
        check("mid_next_last0", 32'(bus.out_last), 32'h0);
        drive(0, 32'h0, 3'd0, 1);
        check("mid_next_beat1", 32'(bus.out_data), 32'h43);
        drive(0, 32'h0, 3'd0, 1);
        drive(0, 32'h0, 3'd0, 1);
        check("mid_next_beat3", {23'h0, bus.out_last, bus.out_data}, {23'h0, 1'b1, 8'h87});
        drive(0, 32'h0, 3'd0, 0);
        check("mid_next_idle", 32'(bus.out_valid), 32'h0);

        // ------------------------------------------------ random valid/ready
        offering = 1'b0;
        sent     = 0;
        cyc      = 0;
        md       = '0;
        ml       = '0;
        while ((sent < NMSG || exp_q.size() > 0 || bus.out_valid) && cyc < BUDGET) begin
            @(posedge clk);
            #2;
            if (!offering && sent < NMSG && $urandom_range(0, 3) != 0) begin
                offering = 1'b1;
                md = $urandom;
                ml = LEN_W'($urandom_range(0, 7));
            end
            bus.in_valid  = offering;
            bus.in_data   = offering ? md : $urandom;
            bus.in_len    = ml;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_beat", {23'h0, bus.out_last, bus.out_data}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("rand_beat", {23'h0, bus.out_last, bus.out_data}, {23'h0, e});
                end
            end
            if (offering && bus.in_ready) begin
                lc = (ml == 0 || ml > NB) ? NB : int'(ml);
                for (int k = 0; k < lc; k++) begin
                    exp_q.push_back({(k == lc - 1), md[k*BW +: BW]});
                end
                sent++;
                offering = 1'b0;
            end
            cyc++;
        end
        check("rand_within_budget", 32'(cyc < BUDGET), 32'h1);
        check("rand_all_sent",      32'(sent), 32'(NMSG));
        check("rand_queue_empty",   32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_stream_serializer
